// File: rtl/arbiter_bus_grant_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_bus_grant_if
// Description : Request/grant bundle between the bus masters and the
//               N-master system-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbiter_bus_grant_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] breq;      // level-held bus request per master
    logic [NUM_MASTERS-1:0] block;     // lock request, honoured for the owner only
    logic [NUM_MASTERS-1:0] bgrant;    // registered one-hot grant
    logic [ID_W-1:0]        grant_id;  // index of current owner, 0 when idle
    logic                   bus_busy;  // any grant active
    logic                   preempt;   // one-cycle pulse on timeout loss

    // Requesting side: drives requests, observes the grant
    modport master (
        output breq,
        output block,
        input  bgrant,
        input  grant_id,
        input  bus_busy,
        input  preempt
    );

    // Arbiter side: observes requests, drives the grant
    modport slave (
        input  breq,
        input  block,
        output bgrant,
        output grant_id,
        output bus_busy,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_bus_grant.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_bus_grant
// Description : N-master bus arbiter, fixed-priority or round-robin, with
//               hold-time preemption, per-owner lock and a registered
//               one-hot grant. Every ownership change passes through IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_bus_grant #(
    parameter int NUM_MASTERS = 4,
    parameter int RR_MODE     = 1,
    parameter int MAX_HOLD    = 16
) (
    input  wire               clk,
    input  wire               rst,
    arbiter_bus_grant_if.slave bus
);

    localparam int ID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam bit              PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] bgrant_q;
    logic [ID_W-1:0]        grant_id_q;
    logic                   preempt_q;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       hold_cnt;
    logic [NUM_MASTERS-1:0] mask;

    logic [NUM_MASTERS-1:0] masked_req;
    logic [NUM_MASTERS-1:0] eligible;
    logic [ID_W-1:0]        winner;
    logic [ID_W-1:0]        scan_idx;
    logic                   found;
    logic [NUM_MASTERS-1:0] winner_onehot;
    logic [ID_W-1:0]        rr_next;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   others_pending;
    logic                   hold_expired;
    logic                   do_release;
    logic                   do_preempt;

    // The preempted master sits out one arbitration, unless it is the only requester
    always_comb begin
        masked_req = bus.breq & ~mask;
        eligible   = (|masked_req) ? masked_req : bus.breq;
    end

    // Winner scan: from index 0 (fixed) or from rr_ptr with wrap (round-robin)
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int off = 0; off < NUM_MASTERS; off++) begin
            if (RR_MODE != 0) begin
                scan_idx = ID_W'((int'(rr_ptr) + off) % NUM_MASTERS);
            end else begin
                scan_idx = ID_W'(off);
            end
            if (!found && eligible[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
        winner_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
        rr_next       = ID_W'((int'(winner) + 1) % NUM_MASTERS);
    end

    // Owner-relative conditions; the hold check also fires at saturation so a
    // released lock can preempt on the next saturated cycle
    always_comb begin
        owner_req      = |(bus.breq & bgrant_q);
        owner_lock     = |(bus.block & bgrant_q);
        others_pending = |(bus.breq & ~bgrant_q);
        hold_expired   = (hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_SAT);
        do_release     = ~owner_req;
        do_preempt     = PREEMPT_EN && hold_expired && !owner_lock
                         && others_pending && owner_req;
    end

    // Arbitration FSM with registered grant, id and preempt pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bgrant_q   <= '0;
            grant_id_q <= '0;
            preempt_q  <= 1'b0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            mask       <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|bus.breq) begin
                        state      <= S_GRANT;
                        bgrant_q   <= winner_onehot;
                        grant_id_q <= winner;
                        rr_ptr     <= rr_next;
                        hold_cnt   <= '0;
                        mask       <= '0;
                    end
                end
                S_GRANT: begin
                    if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (do_release || do_preempt) begin
                        state      <= S_IDLE;
                        bgrant_q   <= '0;
                        grant_id_q <= '0;
                        hold_cnt   <= '0;
                    end
                    if (do_preempt) begin
                        preempt_q <= 1'b1;
                        mask      <= bgrant_q;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bgrant_q <= '0;
                end
            endcase
        end
    end

    assign bus.bgrant   = bgrant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.preempt  = preempt_q;
    assign bus.bus_busy = |bgrant_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_bus_grant.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_bus_grant
// Description : Directed self-checking bench for arbiter_bus_grant using
//               three configurations: fixed/no-timeout, round-robin/
//               no-timeout and fixed/MAX_HOLD=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_bus_grant;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    arbiter_bus_grant_if #(.NUM_MASTERS(4)) if_fx0 ();
    arbiter_bus_grant_if #(.NUM_MASTERS(4)) if_rr0 ();
    arbiter_bus_grant_if #(.NUM_MASTERS(4)) if_fx4 ();

    arbiter_bus_grant #(.NUM_MASTERS(4), .RR_MODE(0), .MAX_HOLD(0)) u_fx0 (
        .clk(clk), .rst(rst), .bus(if_fx0)
    );
    arbiter_bus_grant #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr0 (
        .clk(clk), .rst(rst), .bus(if_rr0)
    );
    arbiter_bus_grant #(.NUM_MASTERS(4), .RR_MODE(0), .MAX_HOLD(4)) u_fx4 (
        .clk(clk), .rst(rst), .bus(if_fx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-hot grant invariant on every instance
    always @(negedge clk) begin
        n_cmp++;
        assert ($onehot0(if_fx0.bgrant) && $onehot0(if_rr0.bgrant) && $onehot0(if_fx4.bgrant)) else begin
            n_err++;
            $error("FAIL onehot observed=%0h/%0h/%0h expected=onehot0",
                   if_fx0.bgrant, if_rr0.bgrant, if_fx4.bgrant);
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if_fx0.breq = '0; if_fx0.block = '0;
        if_rr0.breq = '0; if_rr0.block = '0;
        if_fx4.breq = '0; if_fx4.block = '0;
        tick();
        tick();
        chk("reset_bgrant",   32'(if_rr0.bgrant),   32'h0);
        chk("reset_grant_id", 32'(if_rr0.grant_id), 32'h0);
        chk("reset_busy",     32'(if_rr0.bus_busy), 32'h0);
        chk("reset_preempt",  32'(if_rr0.preempt),  32'h0);
        rst = 1'b0;

        // ---- reset mid-grant (round-robin) ----
        if_rr0.breq = 4'b0010;
        tick();
        chk("rstmid_grant",    32'(if_rr0.bgrant),   32'h2);
        chk("rstmid_id",       32'(if_rr0.grant_id), 32'h1);
        chk("rstmid_busy",     32'(if_rr0.bus_busy), 32'h1);
        tick();
        chk("rstmid_hold",     32'(if_rr0.bgrant),   32'h2);
        rst = 1'b1;
        tick();
        chk("rstmid_bgrant0",  32'(if_rr0.bgrant),   32'h0);
        chk("rstmid_id0",      32'(if_rr0.grant_id), 32'h0);
        chk("rstmid_busy0",    32'(if_rr0.bus_busy), 32'h0);
        chk("rstmid_preempt0", 32'(if_rr0.preempt),  32'h0);
        chk("rstmid_rrptr0",   32'(u_rr0.rr_ptr),    32'h0);
        rst = 1'b0;
        tick();
        chk("rstmid_regrant",  32'(if_rr0.bgrant),   32'h2);
        if_rr0.breq = 4'b0000;
        tick();
        chk("rstmid_release",  32'(if_rr0.bgrant),   32'h0);

        // ---- fixed priority ----
        if_fx0.breq = 4'b1010;
        tick();
        chk("fp_first",   32'(if_fx0.bgrant),   32'h2);
        chk("fp_id1",     32'(if_fx0.grant_id), 32'h1);
        tick();
        chk("fp_hold1",   32'(if_fx0.bgrant),   32'h2);
        tick();
        chk("fp_hold2",   32'(if_fx0.bgrant),   32'h2);
        if_fx0.breq = 4'b1000;
        tick();
        chk("fp_dead",    32'(if_fx0.bgrant),   32'h0);
        chk("fp_deadbsy", 32'(if_fx0.bus_busy), 32'h0);
        chk("fp_deadid",  32'(if_fx0.grant_id), 32'h0);
        tick();
        chk("fp_next",    32'(if_fx0.bgrant),   32'h8);
        chk("fp_id3",     32'(if_fx0.grant_id), 32'h3);
        if_fx0.breq = 4'b0000;
        tick();
        chk("fp_idle",    32'(if_fx0.bgrant),   32'h0);

        // ---- glitch entirely between edges is ignored ----
        if_fx0.breq = 4'b0100;
        #3;
        if_fx0.breq = 4'b0000;
        tick();
        chk("glitch",     32'(if_fx0.bgrant),   32'h0);

        // ---- round-robin fairness ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_rr0.breq = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_grant%0d_c1", k), 32'(if_rr0.bgrant), 32'(1) << (k % 4));
            chk($sformatf("rr_id%0d", k),       32'(if_rr0.grant_id), 32'(k % 4));
            tick();
            chk($sformatf("rr_grant%0d_c2", k), 32'(if_rr0.bgrant), 32'(1) << (k % 4));
            tick();
            chk($sformatf("rr_grant%0d_c3", k), 32'(if_rr0.bgrant), 32'(1) << (k % 4));
            if_rr0.breq[k % 4] = 1'b0;
            tick();
            chk($sformatf("rr_dead%0d", k),     32'(if_rr0.bgrant), 32'h0);
            if_rr0.breq = 4'b1111;
        end
        if_rr0.breq = 4'b0000;
        tick();
        chk("rr_idle",    32'(if_rr0.bgrant),   32'h0);

        // ---- preemption, MAX_HOLD = 4, fixed priority ----
        if_fx4.breq = 4'b0001;
        tick();
        chk("pre_c1",     32'(if_fx4.bgrant),   32'h1);
        tick();
        chk("pre_c2",     32'(if_fx4.bgrant),   32'h1);
        if_fx4.breq = 4'b0101;
        tick();
        chk("pre_c3",     32'(if_fx4.bgrant),   32'h1);
        tick();
        chk("pre_c4",     32'(if_fx4.bgrant),   32'h1);
        chk("pre_c4_p",   32'(if_fx4.preempt),  32'h0);
        tick();
        chk("pre_out",    32'(if_fx4.bgrant),   32'h0);
        chk("pre_pulse",  32'(if_fx4.preempt),  32'h1);
        tick();
        chk("pre_new",    32'(if_fx4.bgrant),   32'h4);
        chk("pre_new_id", 32'(if_fx4.grant_id), 32'h2);
        chk("pre_pulse0", 32'(if_fx4.preempt),  32'h0);
        if_fx4.breq = 4'b0001;
        tick();
        chk("pre_rel",    32'(if_fx4.bgrant),   32'h0);
        tick();
        chk("pre_back0",  32'(if_fx4.bgrant),   32'h1);
        if_fx4.breq = 4'b0000;
        tick();
        chk("pre_idle",   32'(if_fx4.bgrant),   32'h0);

        // ---- lock suppresses preemption ----
        if_fx4.block = 4'b0001;
        if_fx4.breq  = 4'b0001;
        tick();
        chk("lock_grant", 32'(if_fx4.bgrant),   32'h1);
        if_fx4.breq = 4'b0101;
        for (int c = 0; c < 22; c++) begin
            tick();
            chk($sformatf("lock_hold%0d", c), 32'(if_fx4.bgrant),  32'h1);
            chk($sformatf("lock_nop%0d", c),  32'(if_fx4.preempt), 32'h0);
        end
        if_fx4.block = 4'b0000;
        tick();
        chk("unlock_out",   32'(if_fx4.bgrant),  32'h0);
        chk("unlock_pulse", 32'(if_fx4.preempt), 32'h1);
        tick();
        chk("unlock_new",   32'(if_fx4.bgrant),  32'h4);
        if_fx4.breq = 4'b0000;
        tick();
        chk("unlock_idle",  32'(if_fx4.bgrant),  32'h0);

        // ---- release coincides with timeout ----
        if_fx4.breq = 4'b0001;
        tick();
        chk("sim_c1",     32'(if_fx4.bgrant),   32'h1);
        if_fx4.breq = 4'b0101;
        tick();
        chk("sim_c2",     32'(if_fx4.bgrant),   32'h1);
        tick();
        chk("sim_c3",     32'(if_fx4.bgrant),   32'h1);
        tick();
        chk("sim_c4",     32'(if_fx4.bgrant),   32'h1);
        if_fx4.breq = 4'b0100;
        tick();
        chk("sim_rel",    32'(if_fx4.bgrant),   32'h0);
        chk("sim_nopre",  32'(if_fx4.preempt),  32'h0);
        if_fx4.breq = 4'b0101;
        tick();
        chk("sim_unmask", 32'(if_fx4.bgrant),   32'h1);
        if_fx4.breq = 4'b0000;
        tick();
        chk("sim_idle",   32'(if_fx4.bgrant),   32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter_bus_grant.md
# arbiter_bus_grant

Parametrised N-master system-bus arbiter, the next-generation replacement for the two-master grant FSM. It takes one request line per master and issues a registered one-hot grant. Arbitration is fixed-priority or round-robin. The block adds optional hold-time preemption and a per-owner bus lock. It sits between the master interfaces and the bus address/data muxes, which are steered by `grant_id`.

## Interface
- `NUM_MASTERS`, 4, number of requesting masters (2..16)
- `RR_MODE`, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- `MAX_HOLD`, 16, cycles an owner may hold the bus before it can be preempted; 0 disables preemption
- `ID_W`, `$clog2(NUM_MASTERS)`, width of `grant_id` (derived, not overridden)

Ports:
- `clk`  in  1  single system clock; everything on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `breq`  in  NUM_MASTERS  bus request, one bit per master, level-held until done
- `block`  in  NUM_MASTERS  lock request; only `block[owner]` is observed, and only while granted
- `bgrant`  out  NUM_MASTERS  registered one-hot grant
- `grant_id`  out  ID_W  index of current owner; 0 when idle
- `bus_busy`  out  1  high while any grant is active
- `preempt`  out  1  one-cycle pulse when the owner loses the bus by timeout

## Operation
- Two states: IDLE and GRANT.
- **IDLE**
  - `bgrant` = 0.
  - If `breq` != 0, select a winner, register the grant and go to GRANT.
  - Otherwise stay in IDLE.
- **Winner selection, fixed priority (`RR_MODE` = 0):** lowest set index of the eligible requests.
- **Winner selection, round-robin (`RR_MODE` = 1):** first set index at or after `rr_ptr`, wrapping from `NUM_MASTERS-1` to 0.
  - On every grant, `rr_ptr` is loaded with (winner + 1) mod `NUM_MASTERS`.
- **Eligible requests:** `breq` & ~`mask`.
  - `mask` holds the just-preempted master for exactly one arbitration, and only if another request is pending.
  - If the preempted master is the only requester, it is re-granted.
  - `mask` clears after that arbitration.
- **GRANT**
  - `bgrant` holds the owner bit.
  - `hold_cnt` increments each cycle, saturating at `MAX_HOLD`.
  - Release: `breq[owner]` sampled 0 → IDLE, `bgrant` = 0 next cycle.
  - Preempt: all of the following hold → IDLE, `preempt` = 1 for one cycle, `mask` = owner.
    - `MAX_HOLD` != 0
    - `hold_cnt` == `MAX_HOLD`-1
    - `block[owner]` = 0
    - some other `breq` bit set
  - `block[owner]` = 1 suppresses preemption indefinitely; `hold_cnt` keeps saturating.
  - If release and preempt conditions coincide, release wins and `preempt` stays 0.
- **Dead cycle:** every ownership change passes through IDLE, so there is always one cycle with `bgrant` = 0 between owners.
- **Glitch handling:** requests that rise and fall entirely inside the dead cycle are not granted.
- **Reset:** `rst` = 1 at any edge, including mid-grant, forces on the next cycle:
  - IDLE, `bgrant` = 0, `grant_id` = 0, `bus_busy` = 0, `preempt` = 0
  - `hold_cnt` = 0, `rr_ptr` = 0, `mask` = 0
- **Outputs:** `bgrant`, `grant_id` and `preempt` are registered. `bus_busy` is the OR of registered `bgrant` and is glitch-free.

## Timing
- **Request to grant from IDLE:** `breq[i]` sampled 1 at edge k → `bgrant[i]` = 1 after edge k (1 cycle).
- **Release:** `breq[owner]` sampled 0 at edge k → `bgrant` = 0 after edge k.
  - Next owner's grant appears after edge k+1, provided its request is seen at edge k+1.
- **Preempt:** owner is granted for exactly `MAX_HOLD` cycles.
  - `preempt` is high in the first cycle with `bgrant` = 0.
  - The new owner is granted in the following cycle.
- **Handover interval:** minimum two edges from one owner's release to the next owner's grant (one dead cycle).
- **`grant_id` timing:** changes on the same edge as `bgrant` and is 0 in IDLE.
- **One-hot invariant:** at most one `bgrant` bit is ever set; checked by assertion.

## Test plan
- **Reset mid-grant:** N=4, RR, `breq` = 4'b0010 held, `rst` pulsed in GRANT → after the reset edge all outputs 0 and `rr_ptr` = 0. With `rst` low, `bgrant` = 4'b0010 one cycle later.
- **Fixed priority:** `RR_MODE` = 0, `MAX_HOLD` = 0, `breq` = 4'b1010 steady.
  - `bgrant` = 4'b0010 until `breq[1]` drops.
  - Then one dead cycle, then 4'b1000.
- **Round-robin fairness:** `RR_MODE` = 1, `MAX_HOLD` = 0, `breq` = 4'b1111, each owner drops its request for one cycle after 3 granted cycles → grant order 0,1,2,3,0 with one idle cycle between each.
- **Preemption:** `MAX_HOLD` = 4, master 0 holds `breq`, master 2 requests at cycle 2.
  - `bgrant` = 4'b0001 for exactly 4 cycles.
  - `preempt` = 1 with `bgrant` = 0, then 4'b0100.
  - In fixed mode, master 0 does not re-win that arbitration.
- **Lock:** same as the preemption case with `block[0]` = 1 → no preempt for ≥20 cycles. Drop `block[0]` → preempt on the next cycle in which `hold_cnt` is at saturation.
- **Simultaneous release and timeout:** owner drops `breq` in the cycle where `hold_cnt` == `MAX_HOLD`-1 → `preempt` stays 0 and the next arbitration is unmasked.
